fnd_scan_4: RTL and testbench

- Four-digit multiplexed seven-segment (FND) scan driver, placed directly downstream of the 14-bit-to-BCD converter in the watch datapath.
- Captures the converter's four BCD digits (thousands, hundreds, tens, ones) on the rising edge of its done flag.
- Time-multiplexes the digits onto a common-anode display, with leading-zero blanking, per-digit decimal points and an all-off dead-time between digits to suppress ghosting.

---
 rtl/fnd_pkg.sv | 25 ++
 rtl/bcd_to_seg7.sv | 30 +++
 rtl/fnd_scan_4.sv | 105 ++++++++++
 tb/tb_fnd_scan_4.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants for the four-digit FND scan driver: segment codes,
// scan state encoding and the all-off anode pattern.
package fnd_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal codes
// and an explicit blank request both turn every segment off.
module bcd_to_seg7
  import fnd_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/fnd_scan_4.sv
// Four-digit multiplexed common-anode display driver with leading-zero
// blanking, per-digit decimal points and an all-off gap between digits.
module fnd_scan_4
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GAP_CYC  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done,
  input  logic [3:0] bcd_a,
  input  logic [3:0] bcd_b,
  input  logic [3:0] bcd_c,
  input  logic [3:0] bcd_d,
  input  logic [3:0] dp_en,
  input  logic       lzb,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);

  // shadow[0] is the leftmost digit (a), shadow[3] the ones digit (d)
  logic [3:0]  shadow [4];
  logic        done_q;
  state_t      state;
  logic [19:0] div_cnt;
  logic [7:0]  gap_cnt;
  logic [1:0]  idx;

  logic [3:0]  lead_zero;
  logic        blank_sel;
  logic [6:0]  seg_dec;
  logic [3:0]  an_sel;
  logic        dp_sel;

  // lead_zero[i]: digits 0..i are all zero
  always_comb begin
    lead_zero[0] = (shadow[0] == 4'd0);
    for (int i = 1; i < 4; i++)
      lead_zero[i] = lead_zero[i-1] && (shadow[i] == 4'd0);
  end

  assign blank_sel = lzb && (idx != 2'd3) && lead_zero[idx];
  assign an_sel    = ~(4'b1000 >> idx);
  assign dp_sel    = ~dp_en[2'd3 - idx];

  bcd_to_seg7 u_dec (
    .bcd   (shadow[idx]),
    .blank (blank_sel),
    .seg   (seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) shadow[i] <= 4'd0;
      state   <= ST_GAP;
      div_cnt <= '0;
      gap_cnt <= '0;
      idx     <= 2'd3;
      an      <= AN_OFF;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
    end else begin
      done_q <= done;
      if (done && !done_q) begin
        shadow[0] <= bcd_a;
        shadow[1] <= bcd_b;
        shadow[2] <= bcd_c;
        shadow[3] <= bcd_d;
      end
      // Outputs reflect the state of the current cycle, one cycle late
      case (state)
        ST_SCAN: begin
          an  <= an_sel;
          seg <= seg_dec;
          dp  <= dp_sel;
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            state   <= ST_GAP;
          end else begin
            div_cnt <= div_cnt + 20'd1;
          end
        end
        default: begin
          an  <= AN_OFF;
          seg <= SEG_BLANK;
          dp  <= 1'b1;
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            idx     <= idx + 2'd1;
            state   <= ST_SCAN;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fnd_scan_4.sv
// Self-checking bench for fnd_scan_4: a frame-position model checked every
// cycle, plus literal spot checks at hand-computed edges.
module tb_fnd_scan_4;

  localparam int S = 8;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done = 1'b0;
  logic       lzb = 1'b0;
  logic [3:0] bcd_a = 4'd0, bcd_b = 4'd0, bcd_c = 4'd0, bcd_d = 4'd0;
  logic [3:0] dp_en = 4'd0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fnd_scan_4 #(.SCAN_DIV(S), .GAP_CYC(G)) dut (
    .clk   (clk),
    .rst   (rst),
    .done  (done),
    .bcd_a (bcd_a),
    .bcd_b (bcd_b),
    .bcd_c (bcd_c),
    .bcd_d (bcd_d),
    .dp_en (dp_en),
    .lzb   (lzb),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  logic [6:0] seg_tbl [16];
  initial begin
    seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001;
    seg_tbl[2] = 7'b0100100; seg_tbl[3] = 7'b0110000;
    seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
    seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000;
    seg_tbl[8] = 7'b0000000; seg_tbl[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tbl[i] = 7'b1111111;
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got an/seg/dp=%b/%b/%b want %b/%b/%b at %0t",
               name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0], $time);
    end
  endtask

  // Model: ecnt = edges since reset release; output after edge n shows the
  // frame position n-1 and the digits captured up to edge n-1.
  int         ecnt;
  logic [3:0] sh [4];
  logic       done_prev;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  always @(posedge clk) begin : model
    int  m, dig;
    bit  lit, allz, blank;
    if (rst) begin
      ecnt = 0;
      for (int i = 0; i < 4; i++) sh[i] = 4'd0;
      done_prev = 1'b0;
      exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
    end else begin
      m   = ecnt;
      lit = (m >= G) && (((m - G) % (S + G)) < S);
      if (lit) begin
        dig = ((m - G) / (S + G)) % 4;
        exp_an = 4'b1111;
        exp_an[3 - dig] = 1'b0;
        allz = 1'b1;
        for (int i = 0; i <= dig; i++) if (sh[i] != 4'd0) allz = 1'b0;
        blank = (sh[dig] > 4'd9) || (lzb && dig < 3 && allz);
        exp_seg = blank ? 7'b1111111 : seg_tbl[sh[dig]];
        exp_dp  = ~dp_en[3 - dig];
      end else begin
        exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
      end
      if (done && !done_prev) begin
        sh[0] = bcd_a; sh[1] = bcd_b; sh[2] = bcd_c; sh[3] = bcd_d;
      end
      done_prev = done;
      ecnt++;
    end
  end

  always @(negedge clk) begin
    if (rst) check("reset_out", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    else     check("model", {an, seg, dp}, {exp_an, exp_seg, exp_dp});
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (ecnt < n) step();
  endtask

  task automatic lit_at(input string name, input int n, input logic [3:0] a_e,
                        input logic [6:0] s_e, input logic d_e);
    wait_until(n);
    check(name, {an, seg, dp}, {a_e, s_e, d_e});
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    bcd_a = a; bcd_b = b; bcd_c = c; bcd_d = d;
  endtask

  initial begin
    repeat (3) step();
    check("reset_state", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});

    // Test 1: 1,2,3,4 with no blanking
    load(4'd1, 4'd2, 4'd3, 4'd4);
    done = 1'b1;
    rst  = 1'b0;
    step();
    done = 1'b0;
    lit_at("t1_gap0",   2, 4'b1111, 7'b1111111, 1'b1);
    lit_at("t1_a_on",   3, 4'b0111, 7'b1111001, 1'b1);
    lit_at("t1_a_end", 10, 4'b0111, 7'b1111001, 1'b1);
    lit_at("t1_gap1",  11, 4'b1111, 7'b1111111, 1'b1);
    lit_at("t1_b",     13, 4'b1011, 7'b0100100, 1'b1);
    lit_at("t1_c",     23, 4'b1101, 7'b0110000, 1'b1);
    lit_at("t1_d",     33, 4'b1110, 7'b0011001, 1'b1);

    // Test 2: done held high, later input changes must be ignored
    wait_until(40);
    load(4'd5, 4'd6, 4'd7, 4'd8);
    done = 1'b1;
    step();
    load(4'd9, 4'd9, 4'd9, 4'd9);
    repeat (19) step();
    done = 1'b0;
    lit_at("t2_a",  83, 4'b0111, 7'b0010010, 1'b1);
    lit_at("t2_d", 113, 4'b1110, 7'b0000000, 1'b1);

    // Test 3: all zeros with and without leading-zero blanking
    wait_until(120);
    load(4'd0, 4'd0, 4'd0, 4'd0);
    lzb = 1'b1;
    done = 1'b1; step(); done = 1'b0;
    lit_at("t3_lzb_a", 123, 4'b0111, 7'b1111111, 1'b1);
    lit_at("t3_lzb_c", 143, 4'b1101, 7'b1111111, 1'b1);
    lit_at("t3_lzb_d", 153, 4'b1110, 7'b1000000, 1'b1);
    wait_until(160);
    lzb = 1'b0;
    lit_at("t3_nolzb_a", 163, 4'b0111, 7'b1000000, 1'b1);
    lit_at("t3_nolzb_c", 183, 4'b1101, 7'b1000000, 1'b1);

    // Test 4: 0,5,0,7 with blanking and decimal point on digit b
    wait_until(200);
    load(4'd0, 4'd5, 4'd0, 4'd7);
    lzb = 1'b1;
    dp_en = 4'b0100;
    done = 1'b1; step(); done = 1'b0;
    lit_at("t4_a", 203, 4'b0111, 7'b1111111, 1'b1);
    lit_at("t4_b", 213, 4'b1011, 7'b0010010, 1'b0);
    lit_at("t4_c", 223, 4'b1101, 7'b1000000, 1'b1);
    lit_at("t4_d", 233, 4'b1110, 7'b1111000, 1'b1);

    // Test 5: non-decimal code on digit c
    wait_until(240);
    load(4'd1, 4'd2, 4'hB, 4'd4);
    lzb = 1'b0;
    dp_en = 4'b0000;
    done = 1'b1; step(); done = 1'b0;
    lit_at("t5_b", 253, 4'b1011, 7'b0100100, 1'b1);
    lit_at("t5_c", 263, 4'b1101, 7'b1111111, 1'b1);
    lit_at("t5_d", 273, 4'b1110, 7'b0011001, 1'b1);

    // Test 6: reset while digit b is lit
    lit_at("t6_b_lit", 296, 4'b1011, 7'b0100100, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_async_rst", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    step();
    step();
    rst = 1'b0;
    lit_at("t6_gap1", 1, 4'b1111, 7'b1111111, 1'b1);
    lit_at("t6_gap2", 2, 4'b1111, 7'b1111111, 1'b1);
    lit_at("t6_a",    3, 4'b0111, 7'b1000000, 1'b1);
    wait_until(45);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
